// File: rtl/fpu_arbiter_pkg.sv
// Shared FPU opcode encoding and arbiter FSM state type.
package fp;

    typedef enum logic [1:0] {
        FOP_ADD = 2'd0,
        FOP_SUB = 2'd1,
        FOP_MUL = 2'd2,
        FOP_DIV = 2'd3
    } fop_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o
);

    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_o = '0;
        sum     = '0;
        idx     = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + (PW+1)'(off);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[PW-1:0];
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fixed-latency pipelined FPU among NREQ requesters with round-robin
// issue, an index tag pipeline for in-order response routing, and a drain/halt FSM.
module fpu_arbiter
    import fp::*;
#(
    parameter  int NREQ    = 4,
    parameter  int NX      = 8,
    parameter  int NM      = 23,
    parameter  int LATENCY = 3,
    localparam int W       = 1 + NX + NM,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(LATENCY + 3)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [2*NREQ-1:0] REQ_OP,
    input  logic [W*NREQ-1:0] REQ_A,
    input  logic [W*NREQ-1:0] REQ_B,
    output logic              FPU_VALID,
    output logic [1:0]        FPU_OP,
    output logic [W-1:0]      FPU_A,
    output logic [W-1:0]      FPU_B,
    input  logic [W-1:0]      FPU_RES,
    output logic [NREQ-1:0]   RSP_VALID,
    output logic [W-1:0]      RSP_DATA,
    input  logic              HALT,
    output logic              HALTED,
    output arb_state_e        DBG_STATE
);

    typedef struct packed {
        logic          sign;
        logic [NX-1:0] exp;
        logic [NM-1:0] man;
    } ieee754_t;

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fpu_valid_q;
    fop_e              fpu_op_q;
    ieee754_t          fpu_a_q, fpu_b_q;
    logic [IW-1:0]     fpu_idx_q;
    logic [LATENCY-1:0] tag_vld_q;
    logic [IW-1:0]     tag_idx_q [LATENCY];
    logic [NREQ-1:0]   rsp_valid_q;
    logic [W-1:0]      rsp_data_q;

    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     gidx;
    logic              hs;
    logic              rsp_any;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i   (REQ_VALID),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // A transfer happens when REQ_VALID[i] & REQ_READY[i]; READY never waits on
    // anything but arbitration, and is dropped combinationally by HALT or reset.
    assign REQ_READY = (RST_N && state_q == ST_RUN && !HALT) ? grant : '0;
    assign hs        = |REQ_READY;
    assign rsp_any   = |rsp_valid_q;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx = IW'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hs && !rsp_any) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!hs && rsp_any) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Drain completes on the cycle the last response is on the wire.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (HALT)          state_d = ST_DRAIN;
            ST_DRAIN:  if (cnt_d == '0)   state_d = ST_HALTED;
            ST_HALTED: if (!HALT)         state_d = ST_RUN;
            default:                      state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_RUN;
            ptr_q       <= '0;
            cnt_q       <= '0;
            fpu_valid_q <= 1'b0;
            fpu_op_q    <= FOP_ADD;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_idx_q   <= '0;
            tag_vld_q   <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_idx_q[k] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            fpu_valid_q <= hs;
            if (hs) begin
                fpu_op_q  <= fop_e'(REQ_OP[gidx*2 +: 2]);
                fpu_a_q   <= ieee754_t'(REQ_A[gidx*W +: W]);
                fpu_b_q   <= ieee754_t'(REQ_B[gidx*W +: W]);
                fpu_idx_q <= gidx;
            end
            tag_vld_q[0] <= fpu_valid_q;
            tag_idx_q[0] <= fpu_idx_q;
            for (int k = 1; k < LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
            rsp_valid_q <= tag_vld_q[LATENCY-1]
                         ? ({{(NREQ-1){1'b0}}, 1'b1} << tag_idx_q[LATENCY-1]) : '0;
            if (tag_vld_q[LATENCY-1]) begin
                rsp_data_q <= FPU_RES;
            end
        end
    end

    assign FPU_VALID = fpu_valid_q;
    assign FPU_OP    = fpu_op_q;
    assign FPU_A     = fpu_a_q;
    assign FPU_B     = fpu_b_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign HALTED    = (state_q == ST_HALTED);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: behavioural FPU, queue-based reference model, vector table.
module tb_fpu_arbiter;
    import fp::*;

    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op = '0;
    logic [W*NREQ-1:0] req_a = '0;
    logic [W*NREQ-1:0] req_b = '0;
    logic              fpu_valid;
    logic [1:0]        fpu_op;
    logic [W-1:0]      fpu_a, fpu_b, fpu_res;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              halt = 1'b0;
    logic              halted;
    arb_state_e        dbg_state;

    fpu_arbiter #(.NREQ(NREQ), .NX(8), .NM(23), .LATENCY(LAT)) dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
        .REQ_A(req_a), .REQ_B(req_b),
        .FPU_VALID(fpu_valid), .FPU_OP(fpu_op), .FPU_A(fpu_a), .FPU_B(fpu_b),
        .FPU_RES(fpu_res),
        .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
        .HALT(halt), .HALTED(halted), .DBG_STATE(dbg_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // ---------------- behavioural single-precision FPU ----------------
    function automatic real sp2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'b0};
        if (e >= 255) return {d[63], 8'hff, 23'b0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        real ra, rb, r;
        ra = sp2r(a);
        rb = sp2r(b);
        case (op)
            2'd0:    r = ra + rb;
            2'd1:    r = ra - rb;
            2'd2:    r = ra * rb;
            default: r = ra / rb;
        endcase
        return r2sp(r);
    endfunction

    function automatic logic [31:0] rand_fp();
        logic s;
        logic [7:0] e;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(110, 145));
        m = 23'($urandom());
        return {s, e, m};
    endfunction

    logic [31:0] fpu_pipe [LAT];
    always @(posedge clk) begin
        fpu_pipe[0] <= fpu_valid ? fpu_model(fpu_op, fpu_a, fpu_b) : $urandom();
        for (int k = 1; k < LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
    end
    assign fpu_res = fpu_pipe[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } iss_t;
    typedef struct {
        int          due;
        int          idx;
        logic [31:0] data;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t exp_q[$];
    int   m_ptr = 0;
    logic mon_en = 1'b0;
    logic chk_grant = 1'b0;

    logic [3:0]  m_want_rsp, m_want_rdy, m_hs;
    logic [31:0] m_want_data;
    int          m_idx;
    logic        m_found;

    always @(negedge clk) begin
        if (!rst_n) begin
            iss_q.delete();
            exp_q.delete();
            m_ptr = 0;
        end else if (mon_en) begin
            m_want_rsp  = '0;
            m_want_data = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                m_want_rsp  = 4'(1 << exp_q[0].idx);
                m_want_data = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            check("rsp_valid", 32'(rsp_valid), 32'(m_want_rsp));
            if (m_want_rsp != 0) check("rsp_data", rsp_data, m_want_data);

            if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
                check("fpu_valid", 32'(fpu_valid), 32'd1);
                check("fpu_op", 32'(fpu_op), 32'(iss_q[0].op));
                check("fpu_a", fpu_a, iss_q[0].a);
                check("fpu_b", fpu_b, iss_q[0].b);
                void'(iss_q.pop_front());
            end else begin
                check("fpu_idle", 32'(fpu_valid), 32'd0);
            end

            if (chk_grant) begin
                m_want_rdy = '0;
                m_found    = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!m_found && req_valid[(m_ptr + k) % NREQ]) begin
                        m_want_rdy = 4'(1 << ((m_ptr + k) % NREQ));
                        m_found    = 1'b1;
                    end
                end
                check("rr_ready", 32'(req_ready), 32'(m_want_rdy));
            end

            m_hs = req_valid & req_ready;
            if (m_hs != 0) begin
                m_idx = 0;
                for (int i = 0; i < NREQ; i++) if (m_hs[i]) m_idx = i;
                m_ptr = (m_idx + 1) % NREQ;
                iss_q.push_back('{cyc + 1, req_op[2*m_idx +: 2], req_a[W*m_idx +: W],
                                  req_b[W*m_idx +: W]});
                exp_q.push_back('{cyc + LAT + 2, m_idx,
                                  fpu_model(req_op[2*m_idx +: 2], req_a[W*m_idx +: W],
                                            req_b[W*m_idx +: W])});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic [3:0] v);
        @(posedge clk); #1;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_op[2*i +: 2] = 2'($urandom_range(0, 3));
            req_a[W*i +: W]  = rand_fp();
            req_b[W*i +: W]  = rand_fp();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_fpu_valid"}, 32'(fpu_valid), 32'd0);
        check({tag, "_fpu_op"}, 32'(fpu_op), 32'd0);
        check({tag, "_fpu_a"}, fpu_a, 32'd0);
        check({tag, "_fpu_b"}, fpu_b, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;
    vec_t vecs[13];
    int   n_rsp;

    initial begin
        vecs[0]  = '{4'hF, 4'h1};
        vecs[1]  = '{4'hF, 4'h2};
        vecs[2]  = '{4'hF, 4'h4};
        vecs[3]  = '{4'hF, 4'h8};
        vecs[4]  = '{4'hF, 4'h1};
        vecs[5]  = '{4'h9, 4'h8};
        vecs[6]  = '{4'h9, 4'h1};
        vecs[7]  = '{4'h0, 4'h0};
        vecs[8]  = '{4'h5, 4'h4};
        vecs[9]  = '{4'h3, 4'h1};
        vecs[10] = '{4'h2, 4'h2};
        vecs[11] = '{4'h9, 4'h8};
        vecs[12] = '{4'h9, 4'h1};

        // Reset with every requester asking: nothing may be granted.
        req_valid = 4'hF;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = '0;
        mon_en = 1'b1;
        chk_grant = 1'b1;

        // Single ADD from requester 1: 1.0 + 2.0.
        drive(4'h0);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_op[3:2] = 2'(FOP_ADD);
        req_a[63:32] = 32'h3F800000;
        req_b[63:32] = 32'h40000000;
        @(negedge clk);
        check("add_ready", 32'(req_ready), 32'h2);
        drive(4'h0);
        @(negedge clk);
        check("add_issue", 32'(fpu_valid), 32'd1);
        repeat (4) @(negedge clk);
        check("add_rsp_valid", 32'(rsp_valid), 32'h2);
        check("add_rsp_data", rsp_data, 32'h40400000);

        // Round-robin vector table from a fresh pointer.
        do_reset();
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].valid);
            @(negedge clk);
            check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].ready));
        end
        repeat (8) drive(4'h0);

        // Random traffic.
        for (int r = 0; r < 400; r++) drive(4'($urandom_range(0, 15)));
        repeat (8) drive(4'h0);

        // Halt with three operations in flight.
        do_reset();
        chk_grant = 1'b0;
        repeat (3) drive(4'hF);
        @(posedge clk); #1;
        halt = 1'b1;
        @(negedge clk);
        check("halt_ready_now", 32'(req_ready), 32'd0);
        n_rsp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_ready", 32'(req_ready), 32'd0);
            check("drain_halted", 32'(halted), 32'd0);
            if (rsp_valid != 0) n_rsp++;
        end
        check("drain_rsp_count", 32'(n_rsp), 32'd3);
        @(negedge clk);
        check("halted_set", 32'(halted), 32'd1);
        @(posedge clk); #1;
        halt = 1'b0;
        @(negedge clk);
        check("halted_hold", 32'(halted), 32'd1);
        check("halted_no_grant", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("resume_ready", 32'(req_ready), 32'h8);
        check("resume_halted", 32'(halted), 32'd0);
        drive(4'h0);
        chk_grant = 1'b1;
        repeat (8) drive(4'h0);

        // Reset with two operations in flight, pointer left at 3.
        drive(4'b0110);
        drive(4'b0110);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'b1100;
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'h4);
        n_rsp = 0;
        for (int k = 0; k < 9; k++) begin
            drive(4'h0);
            @(negedge clk);
            if (rsp_valid != 0) n_rsp++;
        end
        check("post_reset_rsp_count", 32'(n_rsp), 32'd1);

        mon_en = 1'b0;
        check("model_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters sharing one FPU (2..8).
REQ-002 Parameter NX, default 8, is the exponent width; parameter NM, default 23, is the mantissa width; operand width W = 1+NX+NM.
REQ-003 Parameter LATENCY, default 3, is the fixed FPU pipeline latency in cycles (>=1).
REQ-004 One clock; reset is asynchronous and active-low. Ports: CLK  in  1  clock; RST_N  in  1  async active-low reset.
REQ-005 REQ_VALID  in  NREQ  per-requester operation valid.
REQ-006 REQ_READY  out  NREQ  per-requester accept, at most one bit high.
REQ-007 REQ_OP  in  2*NREQ  per-requester opcode, using the fp package encoding.
REQ-008 REQ_A, REQ_B  in  W*NREQ  per-requester IEEE754 operands; requester i occupies slice [i*W +: W].
REQ-009 FPU_VALID  out  1  issue strobe to the shared FPU; FPU_OP  out  2; FPU_A, FPU_B  out  W.
REQ-010 FPU_RES  in  W  FPU result, valid exactly LATENCY cycles after the FPU_VALID cycle.
REQ-011 RSP_VALID  out  NREQ  one-hot response strobe; RSP_DATA  out  W  response data; requesters cannot stall responses.
REQ-012 HALT  in  1  drain request; HALTED  out  1  arbiter idle with nothing in flight.

Function
REQ-013 REQ_READY[i] shall be high only in RUN, only when REQ_VALID[i]=1, and only for the round-robin winner; a handshake is REQ_VALID[i]&REQ_READY[i].
REQ-014 Round-robin: priority search starts at pointer PTR and wraps upward; after a grant to i, PTR shall become (i+1) mod NREQ; with no grant, PTR shall hold.
REQ-015 At most one handshake per cycle; sustained throughput is one operation per cycle.
REQ-016 FPU_VALID, FPU_OP, FPU_A and FPU_B shall be registered and shall present the granted operation in the cycle after the handshake; FPU_VALID=0 otherwise, and FPU_OP/A/B hold their last value.
REQ-017 A tag pipeline of LATENCY stages shall carry valid plus the requester index alongside each issued operation.
REQ-018 RSP_VALID (one-hot to the tagged requester) and RSP_DATA=FPU_RES shall be registered, asserting LATENCY+1 cycles after FPU_VALID; end-to-end latency from handshake to response is LATENCY+2 cycles.
REQ-019 Response order shall equal issue order; the arbiter shall not inspect or modify data values.
REQ-020 An in-flight counter of width clog2(LATENCY+3) shall increment on handshake and decrement on RSP_VALID; on a simultaneous handshake and response it shall hold.
REQ-021 FSM RUN->DRAIN when HALT=1; REQ_READY shall be forced to 0 in the same cycle HALT is first seen.
REQ-022 FSM DRAIN->HALTED when the in-flight count is 0, regardless of HALT; HALTED->RUN when HALT=0.
REQ-023 HALTED=1 only in the HALTED state; no grants shall occur in DRAIN or HALTED.

Reset
REQ-024 While RST_N=0, outputs shall be held immediately: REQ_READY=0, FPU_VALID=0, FPU_OP/A/B=0, RSP_VALID=0, RSP_DATA=0, HALTED=0; also state=RUN, PTR=0, tag pipeline cleared, count=0.
REQ-025 Operations in flight when reset asserts shall be discarded; no RSP_VALID shall be produced for them after release.

Structure
REQ-026 Opcode constants FOP_ADD=0, FOP_SUB=1, FOP_MUL=2 and FOP_DIV=3 shall live in package fp; operands shall use the existing IEEE754(NX, NM) struct.
REQ-027 Round-robin selection shall be a sub-module rr_arbiter (NREQ; inputs request vector and PTR; output one-hot grant), combinational.

Verification (NREQ=4, LATENCY=3, behavioural FPU model)
REQ-028 Req1 at cycle T: FOP_ADD, A=0x3F800000, B=0x40000000 -> FPU_VALID at T+1; RSP_VALID=4'b0010 with RSP_DATA=0x40400000 at T+5.
REQ-029 All four REQ_VALID held high from reset -> grants 0,1,2,3,0,... one per cycle; responses arrive in the same order, each 5 cycles after its grant.
REQ-030 After a grant to 1 (PTR=2), with req0 and req3 valid -> grant to 3 first, then to 0.
REQ-031 HALT raised with 3 operations in flight -> REQ_READY=0 in that cycle; 3 responses delivered; HALTED=1 the cycle after the last RSP_VALID; HALT=0 -> RUN and grants resume the next cycle.
REQ-032 RST_N pulled low with 2 in flight -> all outputs 0 immediately; no RSP_VALID after release; the first new request from req2 is granted with PTR starting at 0.
